// File: rtl/mainfsm_hs_if.sv
// Control bundle between the decoder/memory/multiplier side and the main
// control FSM: instruction fields and handshake inputs in, datapath controls out.
interface mainfsm_hs_if;
  // Handshakes: MemReq stays high while the FSM waits in a memory state, and
  // the access completes in the cycle MemReady=1. MulStart pulses once on MULEX
  // entry, and the result is taken in the cycle MulDone=1. Each handshake input
  // is sampled only in its own wait state.
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       IsMul;
  logic       MemReady;
  logic       MulDone;

  logic       IRWrite;
  logic       AdrSrc;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       Branch;
  logic       ALUOp;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic       MemReq;
  logic       MulStart;
  logic       Fault;
  logic [1:0] FaultCause;
  logic [3:0] State;

  modport master (
    input  Op, Funct, IsMul, MemReady, MulDone,
    output IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp,
    output ALUSrcA, ALUSrcB, ResultSrc, MemReq, MulStart,
    output Fault, FaultCause, State
  );

  modport slave (
    output Op, Funct, IsMul, MemReady, MulDone,
    input  IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp,
    input  ALUSrcA, ALUSrcB, ResultSrc, MemReq, MulStart,
    input  Fault, FaultCause, State
  );
endinterface

// File: rtl/mainfsm_hs.sv
// Multicycle processor main control FSM with memory ready/valid wait states,
// a per-access timeout, an optional multi-cycle multiply path and a sticky fault.
module mainfsm_hs #(
    parameter int MUL_EN      = 1,
    parameter int MEM_TIMEOUT = 15
) (
    input logic         clk,
    input logic         reset,
    mainfsm_hs_if.master bus
);

    localparam int            CW     = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] TMO    = CW'(MEM_TIMEOUT);
    localparam bit            TMO_EN = (MEM_TIMEOUT > 0);
    localparam bit            MUL_ON = (MUL_EN != 0);

    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADR   = 4'd2;
    localparam logic [3:0] MEMRD    = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWR    = 4'd5;
    localparam logic [3:0] EXECUTER = 4'd6;
    localparam logic [3:0] EXECUTEI = 4'd7;
    localparam logic [3:0] ALUWB    = 4'd8;
    localparam logic [3:0] BRANCH   = 4'd9;
    localparam logic [3:0] MULEX    = 4'd10;
    localparam logic [3:0] MULWB    = 4'd11;
    localparam logic [3:0] FAULT    = 4'd12;

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_UNDEF = 2'b01;
    localparam logic [1:0] CAUSE_TMO   = 2'b10;

    logic [3:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    cause_q, cause_d;
    logic          mul_first_q, mul_first_d;
    logic          wait_st;
    logic          timeout;

    // Funct[4:1] belongs to the datapath decoder, not to sequencing.
    logic unused_funct;
    assign unused_funct = ^bus.Funct[4:1];

    assign wait_st = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
    assign timeout = TMO_EN && wait_st && !bus.MemReady && (cnt_q == TMO);

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            FETCH: begin
                if (bus.MemReady) begin
                    state_d = DECODE;
                end else if (timeout) begin
                    state_d = FAULT;
                    cause_d = CAUSE_TMO;
                end
            end
            DECODE: begin
                case (bus.Op)
                    2'b00: begin
                        if (bus.Funct[5])              state_d = EXECUTEI;
                        else if (bus.IsMul && MUL_ON)  state_d = MULEX;
                        else                           state_d = EXECUTER;
                    end
                    2'b01: state_d = MEMADR;
                    2'b10: state_d = BRANCH;
                    default: begin
                        state_d = FAULT;
                        cause_d = CAUSE_UNDEF;
                    end
                endcase
            end
            MEMADR:   state_d = bus.Funct[0] ? MEMRD : MEMWR;
            MEMRD: begin
                if (bus.MemReady) begin
                    state_d = MEMWB;
                end else if (timeout) begin
                    state_d = FAULT;
                    cause_d = CAUSE_TMO;
                end
            end
            MEMWR: begin
                if (bus.MemReady) begin
                    state_d = FETCH;
                end else if (timeout) begin
                    state_d = FAULT;
                    cause_d = CAUSE_TMO;
                end
            end
            MEMWB:    state_d = FETCH;
            EXECUTER: state_d = ALUWB;
            EXECUTEI: state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            BRANCH:   state_d = FETCH;
            MULEX:    state_d = bus.MulDone ? MULWB : MULEX;
            MULWB:    state_d = FETCH;
            FAULT:    state_d = FAULT;
            default:  state_d = FETCH;
        endcase
    end

    // The count only survives while the FSM keeps waiting in the same memory
    // state; entry, exit and any ready cycle bring it back to zero.
    always_comb begin
        cnt_d = '0;
        if (wait_st && (state_d == state_q) && !bus.MemReady) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign mul_first_d = (state_d == MULEX) && (state_q != MULEX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= FETCH;
            cnt_q       <= '0;
            cause_q     <= CAUSE_NONE;
            mul_first_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cause_q     <= cause_d;
            mul_first_q <= mul_first_d;
        end
    end

    logic       o_irwrite, o_adrsrc, o_nextpc, o_regw, o_memw, o_branch, o_aluop;
    logic [1:0] o_srca, o_srcb, o_ressrc;
    logic       o_memreq, o_mulstart;

    always_comb begin
        o_irwrite  = 1'b0;
        o_adrsrc   = 1'b0;
        o_nextpc   = 1'b0;
        o_regw     = 1'b0;
        o_memw     = 1'b0;
        o_branch   = 1'b0;
        o_aluop    = 1'b0;
        o_srca     = 2'b00;
        o_srcb     = 2'b00;
        o_ressrc   = 2'b00;
        o_memreq   = 1'b0;
        o_mulstart = 1'b0;
        case (state_q)
            FETCH: begin
                o_memreq  = 1'b1;
                o_srca    = 2'b01;
                o_srcb    = 2'b10;
                o_ressrc  = 2'b10;
                o_irwrite = bus.MemReady;
                o_nextpc  = bus.MemReady;
            end
            DECODE: begin
                o_srca   = 2'b01;
                o_srcb   = 2'b10;
                o_ressrc = 2'b10;
            end
            MEMADR:   o_srcb = 2'b01;
            MEMRD: begin
                o_memreq = 1'b1;
                o_adrsrc = 1'b1;
            end
            MEMWR: begin
                o_memreq = 1'b1;
                o_adrsrc = 1'b1;
                o_memw   = 1'b1;
            end
            MEMWB: begin
                o_regw   = 1'b1;
                o_ressrc = 2'b01;
            end
            EXECUTER: o_aluop = 1'b1;
            EXECUTEI: begin
                o_aluop = 1'b1;
                o_srcb  = 2'b01;
            end
            ALUWB:    o_regw = 1'b1;
            BRANCH: begin
                o_branch = 1'b1;
                o_srca   = 2'b10;
                o_srcb   = 2'b01;
                o_ressrc = 2'b10;
            end
            MULEX:    o_mulstart = mul_first_q;
            MULWB: begin
                o_regw   = 1'b1;
                o_ressrc = 2'b11;
            end
            default: ;
        endcase
    end

    assign bus.IRWrite    = o_irwrite;
    assign bus.AdrSrc     = o_adrsrc;
    assign bus.NextPC     = o_nextpc;
    assign bus.RegW       = o_regw;
    assign bus.MemW       = o_memw;
    assign bus.Branch     = o_branch;
    assign bus.ALUOp      = o_aluop;
    assign bus.ALUSrcA    = o_srca;
    assign bus.ALUSrcB    = o_srcb;
    assign bus.ResultSrc  = o_ressrc;
    assign bus.MemReq     = o_memreq;
    assign bus.MulStart   = o_mulstart;
    assign bus.Fault      = (state_q == FAULT);
    assign bus.FaultCause = cause_q;
    assign bus.State      = state_q;

endmodule

// File: tb/tb_mainfsm_hs.sv
// Directed bench for mainfsm_hs: per-cycle expected control words are queued
// from a spec-level model of each state and compared against both instances.
module tb_mainfsm_hs;

  localparam logic [3:0] S_FETCH = 4'd0,  S_DECODE = 4'd1, S_MEMADR = 4'd2,
                         S_MEMRD = 4'd3,  S_MEMWB  = 4'd4, S_MEMWR  = 4'd5,
                         S_EXECR = 4'd6,  S_EXECI  = 4'd7, S_ALUWB  = 4'd8,
                         S_BRANCH = 4'd9, S_MULEX  = 4'd10, S_MULWB = 4'd11,
                         S_FAULT = 4'd12;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mainfsm_hs_if u ();
  mainfsm_hs_if u2 ();

  assign u2.Op       = u.Op;
  assign u2.Funct    = u.Funct;
  assign u2.IsMul    = u.IsMul;
  assign u2.MemReady = u.MemReady;
  assign u2.MulDone  = u.MulDone;

  mainfsm_hs #(.MUL_EN(1), .MEM_TIMEOUT(4)) dut (.clk(clk), .reset(reset), .bus(u.master));
  mainfsm_hs #(.MUL_EN(0), .MEM_TIMEOUT(4)) dut2 (.clk(clk), .reset(reset), .bus(u2.master));

  logic [21:0] exp_q[$];
  logic [3:0]  exp2_q[$];
  int          total = 0;
  int          bad = 0;
  logic [1:0]  exp_cause = 2'b00;
  logic [3:0]  prev_es = S_FETCH;
  int          ms_cnt = 0;
  int          mw_cnt = 0;

  function automatic logic [21:0] model(input logic [3:0] st, input logic mr,
                                        input logic first, input logic [1:0] cause);
    logic irw, adr, npc, rw, mw, br, aop, mreq, ms, flt;
    logic [1:0] sa, sb, rs, fc;
    irw = 0; adr = 0; npc = 0; rw = 0; mw = 0; br = 0; aop = 0;
    mreq = 0; ms = 0; flt = 0; sa = 0; sb = 0; rs = 0; fc = 0;
    case (st)
      S_FETCH:  begin mreq = 1; sa = 2'b01; sb = 2'b10; rs = 2'b10; irw = mr; npc = mr; end
      S_DECODE: begin sa = 2'b01; sb = 2'b10; rs = 2'b10; end
      S_MEMADR: sb = 2'b01;
      S_MEMRD:  begin mreq = 1; adr = 1; end
      S_MEMWR:  begin mreq = 1; adr = 1; mw = 1; end
      S_MEMWB:  begin rw = 1; rs = 2'b01; end
      S_EXECR:  aop = 1;
      S_EXECI:  begin aop = 1; sb = 2'b01; end
      S_ALUWB:  rw = 1;
      S_BRANCH: begin br = 1; sa = 2'b10; sb = 2'b01; rs = 2'b10; end
      S_MULEX:  ms = first;
      S_MULWB:  begin rw = 1; rs = 2'b11; end
      S_FAULT:  begin flt = 1; fc = cause; end
      default: ;
    endcase
    return {st, irw, adr, npc, rw, mw, br, aop, sa, sb, rs, mreq, ms, flt, fc};
  endfunction

  function automatic logic [21:0] observed();
    return {u.State, u.IRWrite, u.AdrSrc, u.NextPC, u.RegW, u.MemW, u.Branch, u.ALUOp,
            u.ALUSrcA, u.ALUSrcB, u.ResultSrc, u.MemReq, u.MulStart, u.Fault, u.FaultCause};
  endfunction

  // One clock cycle: drive at posedge+1, compare at the following negedge.
  task automatic cyc(input string tag, input logic [3:0] es, input logic [1:0] op,
                     input logic [5:0] fn, input logic im, input logic mr, input logic md,
                     input logic chk2, input logic [3:0] es2);
    logic [21:0] e, o;
    logic [3:0]  e2;
    u.Op = op; u.Funct = fn; u.IsMul = im; u.MemReady = mr; u.MulDone = md;
    exp_q.push_back(model(es, mr, (es == S_MULEX) && (prev_es != S_MULEX), exp_cause));
    if (chk2) exp2_q.push_back(es2);
    @(negedge clk);
    o = observed();
    e = exp_q.pop_front();
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, o, e);
    end
    if (chk2) begin
      e2 = exp2_q.pop_front();
      total++;
      assert (u2.State === e2) else begin
        bad++;
        $error("FAIL %s_nomul state got=%0d exp=%0d", tag, u2.State, e2);
      end
    end
    if (u.MulStart) ms_cnt++;
    if (u.MemW) mw_cnt++;
    prev_es = es;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    exp_cause = 2'b00;
    prev_es = S_FETCH;
    cyc(tag, S_FETCH, 2'b00, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, S_FETCH);
    reset = 1'b0;
  endtask

  initial begin
    logic [21:0] e, o;
    reset = 1'b1;
    u.Op = 0; u.Funct = 0; u.IsMul = 0; u.MemReady = 0; u.MulDone = 0;
    @(posedge clk);
    #1;
    cyc("rst_idle", S_FETCH, 2'b00, 6'd0, 0, 0, 0, 1, S_FETCH);
    cyc("rst_mr",   S_FETCH, 2'b00, 6'd0, 0, 1, 0, 1, S_FETCH);
    reset = 1'b0;

    // ADD: 0,1,6,8
    cyc("add_f", S_FETCH,  2'b00, 6'b000100, 0, 1, 0, 1, S_FETCH);
    cyc("add_d", S_DECODE, 2'b00, 6'b000100, 0, 1, 0, 1, S_DECODE);
    cyc("add_e", S_EXECR,  2'b00, 6'b000100, 0, 1, 0, 1, S_EXECR);
    cyc("add_w", S_ALUWB,  2'b00, 6'b000100, 0, 1, 0, 1, S_ALUWB);
    // ADDI
    cyc("addi_f", S_FETCH,  2'b00, 6'b100000, 0, 1, 0, 1, S_FETCH);
    cyc("addi_d", S_DECODE, 2'b00, 6'b100000, 0, 1, 0, 1, S_DECODE);
    cyc("addi_e", S_EXECI,  2'b00, 6'b100000, 0, 1, 0, 1, S_EXECI);
    cyc("addi_w", S_ALUWB,  2'b00, 6'b100000, 0, 1, 0, 1, S_ALUWB);

    // LDR with three wait cycles in MEMRD
    cyc("ldr_f", S_FETCH,  2'b01, 6'b000001, 0, 1, 0, 1, S_FETCH);
    cyc("ldr_d", S_DECODE, 2'b01, 6'b000001, 0, 1'($urandom_range(0, 1)), 0, 1, S_DECODE);
    cyc("ldr_a", S_MEMADR, 2'b01, 6'b000001, 0, 1'($urandom_range(0, 1)), 0, 1, S_MEMADR);
    for (int i = 0; i < 3; i++)
      cyc("ldr_wait", S_MEMRD, 2'b01, 6'b000001, 0, 0, 0, 1, S_MEMRD);
    cyc("ldr_rd", S_MEMRD, 2'b01, 6'b000001, 0, 1, 0, 1, S_MEMRD);
    cyc("ldr_wb", S_MEMWB, 2'b01, 6'b000001, 0, 1, 0, 1, S_MEMWB);

    // LDR: ready arrives exactly when the count reaches MEM_TIMEOUT
    cyc("ldrt_f", S_FETCH,  2'b01, 6'b000001, 0, 1, 0, 1, S_FETCH);
    cyc("ldrt_d", S_DECODE, 2'b01, 6'b000001, 0, 1, 0, 1, S_DECODE);
    cyc("ldrt_a", S_MEMADR, 2'b01, 6'b000001, 0, 1, 0, 1, S_MEMADR);
    for (int i = 0; i < 4; i++)
      cyc("ldrt_wait", S_MEMRD, 2'b01, 6'b000001, 0, 0, 0, 1, S_MEMRD);
    cyc("ldrt_edge", S_MEMRD, 2'b01, 6'b000001, 0, 1, 0, 1, S_MEMRD);
    cyc("ldrt_wb",   S_MEMWB, 2'b01, 6'b000001, 0, 1, 0, 1, S_MEMWB);

    // Branch
    cyc("b_f", S_FETCH,  2'b10, 6'd0, 0, 1, 0, 1, S_FETCH);
    cyc("b_d", S_DECODE, 2'b10, 6'd0, 0, 1, 0, 1, S_DECODE);
    cyc("b_b", S_BRANCH, 2'b10, 6'd0, 0, 1, 0, 1, S_BRANCH);

    // MUL, MulDone five cycles after entry; the MUL_EN=0 instance takes EXECUTER
    ms_cnt = 0;
    cyc("mul_f", S_FETCH,  2'b00, 6'd0, 1, 1, 0, 1, S_FETCH);
    cyc("mul_d", S_DECODE, 2'b00, 6'd0, 1, 0, 1, 1, S_DECODE);
    cyc("mul_x0", S_MULEX, 2'b00, 6'd0, 1, 0, 0, 1, S_EXECR);
    cyc("mul_x1", S_MULEX, 2'b00, 6'd0, 1, 0, 0, 1, S_ALUWB);
    for (int i = 2; i < 5; i++)
      cyc("mul_x", S_MULEX, 2'b00, 6'd0, 1, 0, 0, 0, S_FETCH);
    cyc("mul_done", S_MULEX, 2'b00, 6'd0, 1, 0, 1, 0, S_FETCH);
    cyc("mul_wb",   S_MULWB, 2'b00, 6'd0, 1, 0, 0, 0, S_FETCH);
    total++;
    assert (ms_cnt === 1) else begin
      bad++;
      $error("FAIL mulstart_pulses got=%0d exp=1", ms_cnt);
    end
    // MulDone on the very first MULEX cycle
    cyc("mulq_f", S_FETCH,  2'b00, 6'd0, 1, 1, 0, 0, S_FETCH);
    cyc("mulq_d", S_DECODE, 2'b00, 6'd0, 1, 0, 1, 0, S_FETCH);
    cyc("mulq_x", S_MULEX,  2'b00, 6'd0, 1, 0, 1, 0, S_FETCH);
    cyc("mulq_wb", S_MULWB, 2'b00, 6'd0, 1, 0, 0, 0, S_FETCH);
    do_reset("rst_mul");

    // STR that never completes: five MemW cycles then FAULT/10, held
    mw_cnt = 0;
    cyc("str_f", S_FETCH,  2'b01, 6'd0, 0, 1, 0, 1, S_FETCH);
    cyc("str_d", S_DECODE, 2'b01, 6'd0, 0, 0, 0, 1, S_DECODE);
    cyc("str_a", S_MEMADR, 2'b01, 6'd0, 0, 0, 0, 1, S_MEMADR);
    for (int i = 0; i < 5; i++)
      cyc("str_wait", S_MEMWR, 2'b01, 6'd0, 0, 0, 0, 1, S_MEMWR);
    exp_cause = 2'b10;
    for (int i = 0; i < 3; i++)
      cyc("str_fault", S_FAULT, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)), 0,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, S_FAULT);
    total++;
    assert (mw_cnt === 5) else begin
      bad++;
      $error("FAIL memw_cycles got=%0d exp=5", mw_cnt);
    end
    do_reset("rst_str");

    // Undefined op
    cyc("und_f", S_FETCH,  2'b11, 6'd0, 0, 1, 0, 1, S_FETCH);
    cyc("und_d", S_DECODE, 2'b11, 6'd0, 0, 1, 0, 1, S_DECODE);
    exp_cause = 2'b01;
    cyc("und_fault0", S_FAULT, 2'b00, 6'd0, 0, 1, 0, 1, S_FAULT);
    cyc("und_fault1", S_FAULT, 2'b00, 6'd0, 0, 1, 0, 1, S_FAULT);
    do_reset("rst_und");

    // Fetch timeout
    for (int i = 0; i < 5; i++)
      cyc("fet_wait", S_FETCH, 2'b00, 6'd0, 0, 0, 0, 1, S_FETCH);
    exp_cause = 2'b10;
    cyc("fet_fault", S_FAULT, 2'b00, 6'd0, 0, 0, 0, 1, S_FAULT);
    do_reset("rst_fet");

    // Reset asserted in the middle of a MEMRD wait takes effect without a clock
    cyc("ab_f", S_FETCH,  2'b01, 6'b000001, 0, 1, 0, 1, S_FETCH);
    cyc("ab_d", S_DECODE, 2'b01, 6'b000001, 0, 1, 0, 1, S_DECODE);
    cyc("ab_a", S_MEMADR, 2'b01, 6'b000001, 0, 1, 0, 1, S_MEMADR);
    cyc("ab_w0", S_MEMRD, 2'b01, 6'b000001, 0, 0, 0, 1, S_MEMRD);
    cyc("ab_w1", S_MEMRD, 2'b01, 6'b000001, 0, 0, 0, 1, S_MEMRD);
    #1;
    reset = 1'b1;
    exp_cause = 2'b00;
    prev_es = S_FETCH;
    exp_q.push_back(model(S_FETCH, 1'b0, 1'b0, 2'b00));
    #1;
    o = observed();
    e = exp_q.pop_front();
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL async_reset got=%h exp=%h", o, e);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Recovery after the abort
    cyc("rec_f", S_FETCH,  2'b00, 6'b000100, 0, 1, 0, 1, S_FETCH);
    cyc("rec_d", S_DECODE, 2'b00, 6'b000100, 0, 1, 0, 1, S_DECODE);
    cyc("rec_e", S_EXECR,  2'b00, 6'b000100, 0, 1, 0, 1, S_EXECR);
    cyc("rec_w", S_ALUWB,  2'b00, 6'b000100, 0, 1, 0, 1, S_ALUWB);
    cyc("rec_f2", S_FETCH, 2'b00, 6'b000100, 0, 0, 0, 1, S_FETCH);

    total++;
    assert (exp_q.size() == 0 && exp2_q.size() == 0) else begin
      bad++;
      $error("FAIL queue_drain got=%0d exp=0", exp_q.size() + exp2_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
